// File: rtl/prng_block_filler.sv
// rtl/prng_block_filler.sv - loads a PRNG seed from word RAM, pulses reseed, then
// drains N handshaked PRNG output blocks into consecutive RAM words.
module prng_block_filler #(
   parameter int DATA_W     = 32,
   parameter int SEED_WORDS = 8,
   parameter int RDI_WORDS  = 4,
   parameter int ADDR_W     = 8,
   parameter int CNT_W      = 4,
   parameter int SEED_BASE  = 0,
   parameter int OUT_BASE   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         reseed_en,
   input  logic [CNT_W-1:0]             n_blocks,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_W-1:0]            ram_addr,
   input  logic [DATA_W-1:0]            ram_do,
   output logic [DATA_W-1:0]            ram_di,
   output logic                         ram_we,
   output logic [SEED_WORDS*DATA_W-1:0] seed,
   output logic                         reseed,
   input  logic [RDI_WORDS*DATA_W-1:0]  rdi_data,
   input  logic                         rdi_valid,
   output logic                         rdi_ready
);

   localparam int MAXW = (SEED_WORDS > RDI_WORDS) ? SEED_WORDS : RDI_WORDS;
   localparam int CW   = ($clog2(MAXW) < 1) ? 1 : $clog2(MAXW);
   localparam logic [CW-1:0] SEED_LAST = CW'(SEED_WORDS - 1);
   localparam logic [CW-1:0] RDI_LAST  = CW'(RDI_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SEED_RD, S_SEED_CAP, S_RESEED, S_WAIT_RDI, S_WRITE, S_DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [CNT_W-1:0]              blk_q, blk_d, nblk_q, nblk_d, blk_inc;
   logic [SEED_WORDS*DATA_W-1:0]  seed_q, seed_d;
   logic [RDI_WORDS*DATA_W-1:0]   buf_q, buf_d;
   logic                          busy_q, busy_d, done_q, done_d;
   logic                          reseed_q, reseed_d, rdi_ready_q, rdi_ready_d;
   logic                          ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]             ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]             ram_di_q, ram_di_d;
   logic                          cap_en;
   logic [CW-1:0]                 cap_idx;
   logic [ADDR_W-1:0]             seed_addr, out_addr;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      nblk_d  = nblk_q;
      seed_d  = seed_q;
      buf_d   = buf_q;
      cap_en  = 1'b0;
      cap_idx = '0;
      blk_inc = blk_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               nblk_d = n_blocks;
               blk_d  = '0;
               cnt_d  = '0;
               if (reseed_en)           state_d = S_SEED_RD;
               else if (n_blocks == '0) state_d = S_DONE;
               else                     state_d = S_WAIT_RDI;
            end
         end
         S_SEED_RD: begin
            // read data trails the address by one cycle, so capture the previous word
            cap_en  = (cnt_q != '0);
            cap_idx = cnt_q - 1'b1;
            if (cnt_q == SEED_LAST) begin
               cnt_d   = '0;
               state_d = S_SEED_CAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SEED_CAP: begin
            cap_en  = 1'b1;
            cap_idx = SEED_LAST;
            state_d = S_RESEED;
         end
         S_RESEED: state_d = (nblk_q == '0) ? S_DONE : S_WAIT_RDI;
         S_WAIT_RDI: begin
            if (rdi_valid && rdi_ready_q) begin
               buf_d   = rdi_data;
               cnt_d   = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (cnt_q == RDI_LAST) begin
               cnt_d   = '0;
               blk_d   = blk_inc;
               state_d = (blk_inc == nblk_q) ? S_DONE : S_WAIT_RDI;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      for (int i = 0; i < SEED_WORDS; i++) begin
         if (cap_en && (cap_idx == CW'(i))) seed_d[i*DATA_W +: DATA_W] = ram_do;
      end

      // outputs are registered from the next-state view so they line up with the state
      seed_addr  = ADDR_W'(SEED_BASE) + ADDR_W'(cnt_d);
      out_addr   = ADDR_W'(OUT_BASE) + ADDR_W'(blk_d) * ADDR_W'(RDI_WORDS) + ADDR_W'(cnt_d);
      ram_we_d   = (state_d == S_WRITE);
      ram_addr_d = '0;
      ram_di_d   = '0;
      if (state_d == S_SEED_RD) ram_addr_d = seed_addr;
      if (ram_we_d) begin
         ram_addr_d = out_addr;
         for (int i = 0; i < RDI_WORDS; i++) begin
            if (cnt_d == CW'(i)) ram_di_d = buf_d[i*DATA_W +: DATA_W];
         end
      end
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      reseed_d    = (state_d == S_RESEED);
      rdi_ready_d = (state_d == S_WAIT_RDI);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         blk_q       <= '0;
         nblk_q      <= '0;
         seed_q      <= '0;
         buf_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         reseed_q    <= 1'b0;
         rdi_ready_q <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_di_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         blk_q       <= blk_d;
         nblk_q      <= nblk_d;
         seed_q      <= seed_d;
         buf_q       <= buf_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         reseed_q    <= reseed_d;
         rdi_ready_q <= rdi_ready_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_di_q    <= ram_di_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign reseed    = reseed_q;
   assign rdi_ready = rdi_ready_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_di    = ram_di_q;
   assign seed      = seed_q;

endmodule
